// File: rtl/mult_control_param.sv
// Sequencing controller for an NCHUNK x NCHUNK chunked multiplier sharing one CHUNK x CHUNK unit.
// Optional signed-top-chunk flags are compiled in when MULT_CTRL_SIGNED_EN is defined.
module mult_control_param #(
    parameter int unsigned NCHUNK = 2,
    localparam int unsigned NPP = NCHUNK * NCHUNK,
    localparam int unsigned SW  = $clog2(NPP),
    localparam int unsigned CW  = ($clog2(NCHUNK) > 1) ? $clog2(NCHUNK) : 1,
    localparam int unsigned SHW = ($clog2(2 * NCHUNK - 1) > 1) ? $clog2(2 * NCHUNK - 1) : 1
) (
    input  logic           clk,
    input  logic           reset_a,
    input  logic           start,
`ifdef MULT_CTRL_SIGNED_EN
    input  logic           signed_mode,
    output logic           a_sgn,
    output logic           b_sgn,
`endif
    output logic [CW-1:0]  a_sel,
    output logic [CW-1:0]  b_sel,
    output logic [SHW-1:0] shift_sel,
    output logic [2:0]     state_out,
    output logic           clk_ena,
    output logic           sclr_n,
    output logic           done,
    output logic           busy
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StCalc = 3'd1,
        StDone = 3'd2,
        StErr  = 3'd3
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] step_q, step_d;

`ifdef MULT_CTRL_SIGNED_EN
    logic sgn_q, sgn_d;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = '0;
        a_sel   = '0;
        b_sel   = '0;
        clk_ena = 1'b0;
        sclr_n  = 1'b1;
        done    = 1'b0;
        busy    = 1'b0;
`ifdef MULT_CTRL_SIGNED_EN
        sgn_d   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                // Mealy clear so the accumulator is zeroed on the edge that enters CALC
                if (start) begin
                    state_d = StCalc;
                    sclr_n  = 1'b0;
                    clk_ena = 1'b1;
`ifdef MULT_CTRL_SIGNED_EN
                    sgn_d   = signed_mode;
`endif
                end
            end
            StCalc: begin
                a_sel   = CW'(step_q % NCHUNK);
                b_sel   = CW'(step_q / NCHUNK);
                clk_ena = 1'b1;
                busy    = 1'b1;
`ifdef MULT_CTRL_SIGNED_EN
                sgn_d   = sgn_q;
`endif
                if (start) begin
                    state_d = StErr;
                end else if (step_q == SW'(NPP - 1)) begin
                    state_d = StDone;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            StDone: begin
                done = 1'b1;
                // Back-to-back restart: clear and enable while done is still shown
                if (start) begin
                    state_d = StCalc;
                    sclr_n  = 1'b0;
                    clk_ena = 1'b1;
`ifdef MULT_CTRL_SIGNED_EN
                    sgn_d   = signed_mode;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign shift_sel = SHW'(a_sel) + SHW'(b_sel);
    assign state_out = state_q;

`ifdef MULT_CTRL_SIGNED_EN
    assign a_sgn = sgn_q & (a_sel == CW'(NCHUNK - 1));
    assign b_sgn = sgn_q & (b_sel == CW'(NCHUNK - 1));
`endif

    always_ff @(posedge clk) begin
        if (!reset_a) begin
            state_q <= StIdle;
            step_q  <= '0;
`ifdef MULT_CTRL_SIGNED_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
`ifdef MULT_CTRL_SIGNED_EN
            sgn_q   <= sgn_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_control_param.sv
// Bench for mult_control_param: NCHUNK=2 and NCHUNK=4 instances checked against an
// operation-level model; signed flags are checked when MULT_CTRL_SIGNED_EN is defined.
module tb_mult_control_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, start_r, signed_r;
    bit   use4;
    logic start2, start4;

    assign start2 = use4 ? 1'b0 : start_r;
    assign start4 = use4 ? start_r : 1'b0;

    logic       a2, b2;
    logic [1:0] sh2;
    logic [2:0] st2;
    logic       ce2, sc2, dn2, bz2, as2, bs2;

    logic [1:0] a4, b4;
    logic [2:0] sh4;
    logic [2:0] st4;
    logic       ce4, sc4, dn4, bz4, as4, bs4;

`ifdef MULT_CTRL_SIGNED_EN
    localparam bit SgnEn = 1'b1;
`else
    localparam bit SgnEn = 1'b0;
    assign as2 = 1'b0;
    assign bs2 = 1'b0;
    assign as4 = 1'b0;
    assign bs4 = 1'b0;
`endif

    mult_control_param #(.NCHUNK(2)) dut2 (
        .clk        (clk),
        .reset_a    (reset_a),
        .start      (start2),
`ifdef MULT_CTRL_SIGNED_EN
        .signed_mode(signed_r),
        .a_sgn      (as2),
        .b_sgn      (bs2),
`endif
        .a_sel      (a2),
        .b_sel      (b2),
        .shift_sel  (sh2),
        .state_out  (st2),
        .clk_ena    (ce2),
        .sclr_n     (sc2),
        .done       (dn2),
        .busy       (bz2)
    );

    mult_control_param #(.NCHUNK(4)) dut4 (
        .clk        (clk),
        .reset_a    (reset_a),
        .start      (start4),
`ifdef MULT_CTRL_SIGNED_EN
        .signed_mode(signed_r),
        .a_sgn      (as4),
        .b_sgn      (bs4),
`endif
        .a_sel      (a4),
        .b_sel      (b4),
        .shift_sel  (sh4),
        .state_out  (st4),
        .clk_ena    (ce4),
        .sclr_n     (sc4),
        .done       (dn4),
        .busy       (bz4)
    );

    // {state, a_sel, b_sel, shift_sel, clk_ena, sclr_n, done, busy, a_sgn, b_sgn}
    logic [20:0] obs;
    always_comb begin
        obs = use4 ? {st4, 2'b0, a4, 2'b0, b4, 1'b0, sh4, ce4, sc4, dn4, bz4, as4, bs4}
                   : {st2, 3'b0, a2, 3'b0, b2, 2'b0, sh2, ce2, sc2, dn2, bz2, as2, bs2};
    end

    int n_tests = 0;
    int n_fail  = 0;
    int nch     = 2;

    task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] vec(input int st, input int a, input int b, input bit ce,
                                        input bit sc, input bit dn, input bit bz, input bit as,
                                        input bit bs);
        int sh;
        sh = a + b;
        return {st[2:0], a[3:0], b[3:0], sh[3:0], ce, sc, dn, bz, as, bs};
    endfunction

    function automatic logic [20:0] idle_v(input bit st);
        return st ? vec(0, 0, 0, 1, 0, 0, 0, 0, 0) : vec(0, 0, 0, 0, 1, 0, 0, 0, 0);
    endfunction

    function automatic logic [20:0] calc_v(input int s, input bit cap);
        int a, b;
        a = s % nch;
        b = s / nch;
        return vec(1, a, b, 1, 1, 0, 1, SgnEn & cap & (a == nch - 1),
                   SgnEn & cap & (b == nch - 1));
    endfunction

    function automatic logic [20:0] done_v(input bit restart);
        return vec(2, 0, 0, restart, !restart, 1, 0, 0, 0);
    endfunction

    function automatic logic [20:0] err_v();
        return vec(3, 0, 0, 0, 1, 0, 0, 0, 0);
    endfunction

    // Apply inputs for one cycle, then settle to the mid-cycle sample point
    task automatic drive(input logic st, input logic rst, input logic sm);
        start_r  = st;
        reset_a  = rst;
        signed_r = sm;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE: optional abort / reset at a step, optional chained restarts
    task automatic run_op(input bit sel, input int abort_at, input int hold, input int rst_at,
                          input int n_restart, input bit sm0);
        bit cap, ab, rs, smn;
        int rem;
        use4 = sel;
        nch  = sel ? 4 : 2;
        drive(1'b1, 1'b1, sm0);
        check_eq($sformatf("idle_start n%0d", nch), obs, idle_v(1'b1));
        adv();
        cap = sm0;
        rem = n_restart;
        while (1) begin
            for (int s = 0; s < nch * nch; s++) begin
                ab = (s == abort_at);
                rs = (s == rst_at);
                drive(ab, !rs, !cap);
                check_eq($sformatf("calc n%0d s%0d", nch, s), obs, calc_v(s, cap));
                adv();
                if (ab) begin
                    for (int h = 0; h < hold; h++) begin
                        drive(1'b1, 1'b1, 1'($urandom_range(0, 1)));
                        check_eq($sformatf("err_hold n%0d h%0d", nch, h), obs, err_v());
                        adv();
                    end
                    drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
                    check_eq($sformatf("err_exit n%0d", nch), obs, err_v());
                    adv();
                    drive(1'b0, 1'b1, 1'b0);
                    check_eq($sformatf("idle_after_err n%0d", nch), obs, idle_v(1'b0));
                    adv();
                    return;
                end
                if (rs) begin
                    drive(1'b0, 1'b1, 1'b0);
                    check_eq($sformatf("idle_after_rst n%0d", nch), obs, idle_v(1'b0));
                    adv();
                    return;
                end
            end
            smn = 1'($urandom_range(0, 1));
            drive(rem > 0, 1'b1, smn);
            check_eq($sformatf("done n%0d", nch), obs, done_v(rem > 0));
            adv();
            if (rem == 0) break;
            rem--;
            cap = smn;
        end
        drive(1'b0, 1'b1, 1'b0);
        check_eq($sformatf("idle_after_done n%0d", nch), obs, idle_v(1'b0));
        adv();
    endtask

    initial begin
        int kind, npp, stp;
        bit sel;
        reset_a  = 1'b0;
        start_r  = 1'b0;
        signed_r = 1'b0;
        use4     = 1'b0;
        adv();
        adv();
        drive(1'b0, 1'b0, 1'b0);
        check_eq("reset n2", obs, idle_v(1'b0));
        use4 = 1'b1;
        #1;
        check_eq("reset n4", obs, idle_v(1'b0));
        adv();

        run_op(1'b0, -1, 0, -1, 0, 1'b0);
        run_op(1'b1, -1, 0, -1, 0, 1'b0);
        run_op(1'b0, 2, 3, -1, 0, 1'b0);
        run_op(1'b0, -1, 0, -1, 1, 1'b0);
        run_op(1'b0, -1, 0, 1, 0, 1'b0);
        run_op(1'b0, -1, 0, -1, 0, 1'b0);
        run_op(1'b0, -1, 0, -1, 0, 1'b1);
        run_op(1'b1, -1, 0, -1, 0, 1'b1);
        run_op(1'b0, 3, 0, -1, 0, 1'b1);

        repeat (40) begin
            sel  = 1'($urandom_range(0, 1));
            npp  = sel ? 16 : 4;
            kind = $urandom_range(0, 3);
            stp  = $urandom_range(0, npp - 1);
            case (kind)
                1:       run_op(sel, stp, $urandom_range(0, 3), -1, 0, 1'($urandom_range(0, 1)));
                2:       run_op(sel, -1, 0, stp, 0, 1'($urandom_range(0, 1)));
                3:       run_op(sel, -1, 0, -1, $urandom_range(1, 2), 1'($urandom_range(0, 1)));
                default: run_op(sel, -1, 0, -1, 0, 1'($urandom_range(0, 1)));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
